// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the gray_counter codebase slice.
// Functions work on zero-extended values up to GRAY_MAX_W bits, so any N <= 32 can use them.
package gray_pkg;

  localparam int unsigned GRAY_MAX_W = 32;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Upper bits of a zero-extended Gray value are 0, so decoding from the top is width-agnostic.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b = '0;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Maximum count 2**n-1 for a counter of width n (1 <= n <= GRAY_MAX_W).
  function automatic logic [GRAY_MAX_W-1:0] max_count(input int unsigned n);
    return {GRAY_MAX_W{1'b1}} >> (GRAY_MAX_W - n);
  endfunction

endpackage

// File: rtl/gray_counter_next.sv
// Combinational next-state for gray_counter: load/step/hold priority plus wrap detect.
module gray_counter_next
  import gray_pkg::*;
#(
  parameter int unsigned N        = 8,
  parameter bit          SATURATE = 1'b0
) (
  input  logic [N-1:0] bin_out,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [N-1:0] load_bin,
  output logic [N-1:0] next_bin,
  output logic [N-1:0] next_gray,
  output logic         wrap_hit
);

  localparam logic [N-1:0] MAX_N = N'(max_count(N));

  always_comb begin
    next_bin = bin_out;
    wrap_hit = 1'b0;
    if (load) begin
      next_bin = load_bin;
    end else if (en && up) begin
      if (bin_out == MAX_N) begin
        if (!SATURATE) begin
          next_bin = '0;
          wrap_hit = 1'b1;
        end
      end else begin
        next_bin = bin_out + N'(1);
      end
    end else if (en) begin
      if (bin_out == '0) begin
        if (!SATURATE) begin
          next_bin = MAX_N;
          wrap_hit = 1'b1;
        end
      end else begin
        next_bin = bin_out - N'(1);
      end
    end
    next_gray = N'(bin2gray(GRAY_MAX_W'(next_bin)));
  end

endmodule

// File: rtl/gray_counter.sv
// Up/down counter with registered binary and Gray outputs and terminal-count flags.
// Optional sticky consistency checker enabled by defining GRAY_COUNTER_CHECK_EN.
module gray_counter
  import gray_pkg::*;
#(
  parameter int unsigned N        = 8,
  parameter int unsigned RST_VAL  = 0,
  parameter bit          SATURATE = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [N-1:0] load_bin,
  output logic [N-1:0] bin_out,
  output logic [N-1:0] gray_out,
  output logic         at_max,
  output logic         at_min,
  output logic         wrapped
`ifdef GRAY_COUNTER_CHECK_EN
  ,
  output logic         err
`endif
);

  localparam logic [N-1:0] MAX_N    = N'(max_count(N));
  localparam logic [N-1:0] RST_BIN  = N'(RST_VAL);
  localparam logic [N-1:0] RST_GRAY = N'(bin2gray(GRAY_MAX_W'(RST_BIN)));

  logic [N-1:0] next_bin;
  logic [N-1:0] next_gray;
  logic         wrap_hit;

  gray_counter_next #(
    .N        (N),
    .SATURATE (SATURATE)
  ) u_next (
    .bin_out   (bin_out),
    .en        (en),
    .up        (up),
    .load      (load),
    .load_bin  (load_bin),
    .next_bin  (next_bin),
    .next_gray (next_gray),
    .wrap_hit  (wrap_hit)
  );

  // All outputs share one edge so binary, Gray and flags are always mutually consistent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_out  <= RST_BIN;
      gray_out <= RST_GRAY;
      at_max   <= (RST_BIN == MAX_N);
      at_min   <= (RST_BIN == '0);
      wrapped  <= 1'b0;
    end else begin
      bin_out  <= next_bin;
      gray_out <= next_gray;
      at_max   <= (next_bin == MAX_N);
      at_min   <= (next_bin == '0);
      wrapped  <= wrap_hit;
    end
  end

`ifdef GRAY_COUNTER_CHECK_EN
  logic [N-1:0] gray_d;
  logic         load_d;
  logic         chk_bad_c;

  // Flags multi-bit Gray steps on non-load edges and Gray/binary disagreement.
  always_comb begin
    chk_bad_c = 1'b0;
    if (!load_d && ($countones(gray_out ^ gray_d) > 1)) chk_bad_c = 1'b1;
    if (gray2bin(GRAY_MAX_W'(gray_out)) != GRAY_MAX_W'(bin_out)) chk_bad_c = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_d <= RST_GRAY;
      load_d <= 1'b0;
      err    <= 1'b0;
    end else begin
      gray_d <= gray_out;
      load_d <= load;
      err    <= err | chk_bad_c;
    end
  end
`endif

endmodule

// File: tb/tb_gray_counter.sv
// Directed self-checking bench for gray_counter (N=4): wrap, saturate, load and async reset.
module tb_gray_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en, up, load;
  logic [3:0] load_bin;

  logic [3:0] b0, g0, b5, g5, bs, gs;
  logic       mx0, mn0, w0, mx5, mn5, w5, mxs, mns, ws;
`ifdef GRAY_COUNTER_CHECK_EN
  logic       e0, e5, es;
`endif

  int checks = 0;
  int errors = 0;

  logic [3:0] gtab [16];
  logic [3:0] prev_g;

  always #5 clk = ~clk;

  gray_counter #(.N(4), .RST_VAL(0), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_bin(load_bin),
    .bin_out(b0), .gray_out(g0), .at_max(mx0), .at_min(mn0), .wrapped(w0)
`ifdef GRAY_COUNTER_CHECK_EN
    , .err(e0)
`endif
  );

  gray_counter #(.N(4), .RST_VAL(5), .SATURATE(1'b0)) u_rst5 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_bin(load_bin),
    .bin_out(b5), .gray_out(g5), .at_max(mx5), .at_min(mn5), .wrapped(w5)
`ifdef GRAY_COUNTER_CHECK_EN
    , .err(e5)
`endif
  );

  gray_counter #(.N(4), .RST_VAL(0), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_bin(load_bin),
    .bin_out(bs), .gray_out(gs), .at_max(mxs), .at_min(mns), .wrapped(ws)
`ifdef GRAY_COUNTER_CHECK_EN
    , .err(es)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    gtab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
             4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    en = 1'b0; up = 1'b0; load = 1'b0; load_bin = 4'h0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst0_bin", 32'(b0), 32'h0);
    chk("rst0_gray", 32'(g0), 32'h0);
    chk("rst0_min", 32'(mn0), 32'h1);
    chk("rst0_max", 32'(mx0), 32'h0);
    chk("rst0_wrap", 32'(w0), 32'h0);
    chk("rst5_bin", 32'(b5), 32'h5);
    chk("rst5_gray", 32'(g5), 32'h7);
    chk("rst5_max", 32'(mx5), 32'h0);
    chk("rst5_min", 32'(mn5), 32'h0);
    chk("rst5_wrap", 32'(w5), 32'h0);
    chk("rsts_bin", 32'(bs), 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rel5_bin", 32'(b5), 32'h5);
    chk("rel5_gray", 32'(g5), 32'h7);

    // Count up 16 steps through the full range and back to 0.
    en = 1'b1; up = 1'b1;
    prev_g = g0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("up_bin", 32'(b0), 32'(k % 16));
      chk("up_gray", 32'(g0), 32'(gtab[k % 16]));
      chk("up_1bit", 32'($countones(g0 ^ prev_g)), 32'h1);
      chk("up_wrap", 32'(w0), (k == 16) ? 32'h1 : 32'h0);
      chk("up_max", 32'(mx0), (k == 15) ? 32'h1 : 32'h0);
      prev_g = g0;
    end
    chk("sat_top_bin", 32'(bs), 32'hF);
    chk("sat_top_wrap", 32'(ws), 32'h0);
    chk("sat_top_max", 32'(mxs), 32'h1);
    chk("r5_round_bin", 32'(b5), 32'h5);
    tick();
    chk("wrap_pulse_end", 32'(w0), 32'h0);
    chk("after_wrap_bin", 32'(b0), 32'h1);

    // Saturate at max.
    load = 1'b1; load_bin = 4'hF;
    tick();
    chk("ld15_bin", 32'(bs), 32'hF);
    load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("sat_hold_bin", 32'(bs), 32'hF);
      chk("sat_hold_max", 32'(mxs), 32'h1);
      chk("sat_hold_wrap", 32'(ws), 32'h0);
    end
    up = 1'b0;
    tick();
    chk("sat_dec_bin", 32'(bs), 32'hE);
    chk("sat_dec_gray", 32'(gs), 32'h9);
    chk("sat_dec_max", 32'(mxs), 32'h0);

    // Decrement from 0: wrap vs saturate.
    load = 1'b1; load_bin = 4'h0;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b0;
    tick();
    chk("dec0_bin", 32'(b0), 32'hF);
    chk("dec0_gray", 32'(g0), 32'h8);
    chk("dec0_wrap", 32'(w0), 32'h1);
    chk("dec0_max", 32'(mx0), 32'h1);
    chk("dec0_min", 32'(mn0), 32'h0);
    chk("sat_dec0_bin", 32'(bs), 32'h0);
    chk("sat_dec0_wrap", 32'(ws), 32'h0);
    chk("sat_dec0_min", 32'(mns), 32'h1);
    en = 1'b0;
    tick();
    chk("dec0_pulse_end", 32'(w0), 32'h0);
    chk("dec0_hold", 32'(b0), 32'hF);

    // Load beats a simultaneous step.
    load = 1'b1; load_bin = 4'h9; en = 1'b1; up = 1'b1;
    tick();
    chk("ldpri_bin", 32'(b0), 32'h9);
    chk("ldpri_gray", 32'(g0), 32'hD);
    chk("ldpri_wrap", 32'(w0), 32'h0);
    en = 1'b0;
    tick();
    chk("ldsame_bin", 32'(b0), 32'h9);
    chk("ldsame_gray", 32'(g0), 32'hD);

    // Asynchronous reset mid-cycle at bin_out=7.
    load_bin = 4'h7;
    tick();
    chk("ld7_bin", 32'(b0), 32'h7);
    load = 1'b1; load_bin = 4'h3; en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_bin", 32'(b0), 32'h0);
    chk("arst_gray", 32'(g0), 32'h0);
    chk("arst_min", 32'(mn0), 32'h1);
    chk("arst5_bin", 32'(b5), 32'h5);
    chk("arst5_gray", 32'(g5), 32'h7);
    chk("arsts_bin", 32'(bs), 32'h0);
    tick();
    chk("arst_hold_bin", 32'(b0), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; load = 1'b0; en = 1'b0;
    tick();
    chk("post_rst_bin", 32'(b0), 32'h0);

`ifdef GRAY_COUNTER_CHECK_EN
    chk("err_wrap", 32'(e0), 32'h0);
    chk("err_rst5", 32'(e5), 32'h0);
    chk("err_sat", 32'(es), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Parametrised up/down counter that holds its state in binary and also presents a registered Gray-coded copy.
- The Gray output changes exactly one bit per step, so it can drive async-FIFO pointers and other clock-domain-crossing consumers without glitches.
- Supports load, enable, wrap or saturate mode, and terminal-count flags.
- Sits beside the combinational Gray encoders as the stateful building block for FIFO pointer logic.

Parameters:
- N, 8, counter width in bits; N >= 2.
- RST_VAL, 0, binary value loaded on reset; must be < 2**N.
- SATURATE, 0, 0 = wrap at the ends of the range, 1 = hold at the ends of the range.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  step enable.
- up  in  1  direction when en=1: 1 = increment, 0 = decrement.
- load  in  1  synchronous load request.
- load_bin  in  N  binary value to load.
- bin_out  out  N  registered binary count.
- gray_out  out  N  registered Gray code of bin_out.
- at_max  out  1  registered; high when bin_out == 2**N-1.
- at_min  out  1  registered; high when bin_out == 0.
- wrapped  out  1  one-cycle pulse on the cycle after a step crossed max->0 or 0->max.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - bin_out = RST_VAL.
  - gray_out = RST_VAL ^ (RST_VAL>>1).
  - at_max and at_min reflect RST_VAL.
  - wrapped = 0.
- Reset release: synchronous to clk; the first update happens on the first rising edge with rst_n=1.
- Next-state priority, evaluated each rising edge:
  1. load=1: next = load_bin. en and up are ignored. wrapped = 0.
  2. en=1, up=1: next = bin_out+1 modulo 2**N.
     - SATURATE=0: at max, next = 0 and wrapped = 1.
     - SATURATE=1: at max, next = max (hold) and wrapped = 0.
  3. en=1, up=0: next = bin_out-1 modulo 2**N.
     - SATURATE=0: at 0, next = max and wrapped = 1.
     - SATURATE=1: at 0, next = 0 (hold) and wrapped = 0.
  4. Otherwise: hold; wrapped = 0.
- gray_out is registered from next, i.e. next ^ (next>>1), on the same edge as bin_out. It is never derived combinationally from bin_out, so the two outputs are always consistent in the same cycle.
- Latency: one clock from input to all outputs.
- Gray property: with load=0, every edge changes gray_out by exactly 0 or 1 bit, including across a wrap. A load may change any number of bits.
- at_max, at_min and wrapped are computed from next and registered, so they have no combinational path from the inputs.
- Reset mid-operation: the asynchronous reset overrides everything immediately. Pending load or step requests are discarded.
- A load of a value equal to bin_out is legal and produces no output change.

Optional Feature:
- Macro: GRAY_COUNTER_CHECK_EN.
- Defined:
  - Adds output err (1 bit, reset 0). err is sticky and is set when a non-load edge changes gray_out by more than one bit, or when gray2bin(gray_out) != bin_out.
  - err clears only on reset.
  - The check compares against a one-cycle-delayed copy of gray_out and a load-flag register.
- Undefined: the err port, the check logic and the extra registers are absent.

Decomposition:
- Shared package/include gray_pkg:
  - Gray encode and decode functions, parametrised by width.
  - The localparam for the maximum count (2**N-1).
- Sub-module gray_counter_next (combinational):
  - Inputs: bin_out, en, up, load, load_bin, SATURATE.
  - Outputs: next_bin, next_gray, wrap_hit.
- The top level holds only the registers and the optional checker.

Test Plan (N=4 unless stated):
- Reset with RST_VAL=5, then release -> bin_out=5, gray_out=4'b0111, at_max=0, at_min=0, wrapped=0.
- Reset to 0, en=1, up=1 for 16 clocks -> sequence 0..15 then 0; gray_out goes 0000,0001,0011,...,1000,0000; exactly 1 bit changes per edge; wrapped pulses once on the 15->0 edge.
- SATURATE=1, load 15, en=1, up=1 for 3 clocks -> bin_out stays 15, at_max=1, wrapped=0. Then up=0 for 1 clock -> bin_out=14.
- Decrement from 0 with SATURATE=0 -> bin_out=15, gray_out=1000, wrapped=1 for one cycle, at_max=1.
- load=1, load_bin=9 with en=1, up=1 on the same edge -> bin_out=9, not 10; gray_out=1101.
- Assert rst_n low mid-count at bin_out=7 between clock edges -> outputs return to RST_VAL immediately without waiting for a clock. With GRAY_COUNTER_CHECK_EN defined, err stays 0 for the whole run.
